// File: rtl/bias_relu_stage.sv
// -----------------------------------------------------------------------------
// bias_relu_stage
//
// Two-stage post-processing pipeline that sits behind an adder tree. Every
// cycle it can accept one vector of N_adder_tree signed 18-bit lanes, add a
// constant per-lane bias, saturate the result back to 18 bits, optionally
// clamp negatives to zero (ReLU), and hand the vector downstream under a
// valid/ready handshake. It also tags each delivered vector with its position
// inside the current feature map.
//
// Parameters
//   N_adder_tree : number of parallel 18-bit lanes
//   NUM_OUT      : vectors per feature map before out_idx wraps (must be >= 2)
//   RELU_EN      : 1 = clamp negative results to zero, 0 = pass saturated sum
//
// Ports
//   clk       in   rising-edge clock for all state
//   rst       in   synchronous active-high reset
//   bias      in   per-lane bias, lane i at [18*(i+1)-1 : 18*i]
//   sum_in    in   adder-tree result, same lane packing as bias
//   in_valid  in   sum_in carries a vector
//   in_ready  out  vector on sum_in is accepted this cycle
//   out_data  out  biased, saturated, activated vector, same lane packing
//   out_valid out  out_data carries a vector
//   out_ready in   downstream accepts out_data this cycle
//   out_idx   out  index of the presented vector within the feature map
//   out_last  out  presented vector is the last one of the feature map
// -----------------------------------------------------------------------------
module bias_relu_stage #(
    parameter int N_adder_tree = 16,
    parameter int NUM_OUT      = 64,
    parameter int RELU_EN      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_adder_tree*18-1:0]   bias,
    input  logic [N_adder_tree*18-1:0]   sum_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [N_adder_tree*18-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_OUT)-1:0]   out_idx,
    output logic                         out_last
);

    localparam int LANE_W = 18;
    localparam int SUM_W  = LANE_W + 1;
    localparam int VEC_W  = N_adder_tree * LANE_W;
    localparam int SUMV_W = N_adder_tree * SUM_W;
    localparam int IDX_W  = $clog2(NUM_OUT);

    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(NUM_OUT - 1);
    localparam logic [LANE_W-1:0] SAT_MAX = 18'h1FFFF;  // +131071
    localparam logic [LANE_W-1:0] SAT_MIN = 18'h20000;  // -131072

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [SUMV_W-1:0] s1_sum_q,    s1_sum_d;
    logic              s1_valid_q,  s1_valid_d;
    logic [VEC_W-1:0]  out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  out_idx_q,   out_idx_d;

    logic adv;
    logic in_xfer;
    logic out_xfer;

    // -------------------------------------------------------------------------
    // Saturate a 19-bit sum to the 18-bit range, then optionally apply ReLU.
    // Two 18-bit operands can overflow by at most one bit, so the result is
    // out of range exactly when the two top bits of the 19-bit sum disagree;
    // the top bit then tells which rail to clamp to.
    // -------------------------------------------------------------------------
    function automatic logic [LANE_W-1:0] sat_relu(input logic [SUM_W-1:0] s);
        logic [LANE_W-1:0] r;
        if (s[SUM_W-1] != s[SUM_W-2]) begin
            r = s[SUM_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            r = s[LANE_W-1:0];
        end
        if ((RELU_EN != 0) && r[LANE_W-1]) begin
            r = '0;
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // The whole pipeline moves as one unit: it advances whenever the output
    // register is empty or being drained. While reset is held the block still
    // advertises ready, but nothing it sees is kept.
    always_comb begin
        adv      = !out_valid_q || out_ready;
        in_ready = rst || adv;
        in_xfer  = in_valid && adv;
        out_xfer = out_valid_q && out_ready;
    end

    // -------------------------------------------------------------------------
    // Stage 1: sign-extend both operands and add
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first (here
    // "hold the current value"), so no path leaves it unassigned and no latch
    // is inferred.
    always_comb begin
        s1_sum_d   = s1_sum_q;
        s1_valid_d = s1_valid_q;
        if (adv) begin
            // A stalled-free slot with no input becomes a bubble.
            s1_valid_d = in_xfer;
            if (in_valid) begin
                for (int i = 0; i < N_adder_tree; i++) begin
                    s1_sum_d[SUM_W*i +: SUM_W] =
                        {sum_in[LANE_W*i + LANE_W-1], sum_in[LANE_W*i +: LANE_W]} +
                        {bias[LANE_W*i + LANE_W-1],   bias[LANE_W*i +: LANE_W]};
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: saturate + activate into the output register
    // -------------------------------------------------------------------------
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            // Only a real vector overwrites out_data; a bubble leaves the
            // previous contents in place since they are not presented anyway.
            if (s1_valid_q) begin
                for (int i = 0; i < N_adder_tree; i++) begin
                    out_data_d[LANE_W*i +: LANE_W] = sat_relu(s1_sum_q[SUM_W*i +: SUM_W]);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Feature-map position counter
    // -------------------------------------------------------------------------
    always_comb begin
        out_idx_d = out_idx_q;
        if (out_xfer) begin
            out_idx_d = (out_idx_q == IDX_MAX) ? '0 : out_idx_q + IDX_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every flop
    // samples the values that existed before the clock edge regardless of the
    // order in which the simulator evaluates the blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
        end
    end

    // NOTE: the stage-1 sums are qualified by s1_valid_q, so they carry no
    // reset; leaving wide datapath registers out of the reset tree keeps reset
    // fan-out down and lets these map onto plain enable flops.
    always_ff @(posedge clk) begin
        s1_sum_q <= s1_sum_d;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        out_data  = out_data_q;
        out_valid = out_valid_q;
        out_idx   = out_idx_q;
        out_last  = out_valid_q && (out_idx_q == IDX_MAX);
    end

endmodule

// File: tb/tb_bias_relu_stage.sv
// -----------------------------------------------------------------------------
// tb_bias_relu_stage
//
// Two instances share every input: one with ReLU enabled, one passing the
// saturated sum. A queue-based reference model predicts each delivered vector
// from plain integer arithmetic (add, clamp, ReLU) and a running output count
// gives the expected feature-map index. Directed sections pin the model with
// hand-computed values; a long random section follows.
// -----------------------------------------------------------------------------
module tb_bias_relu_stage;

    localparam int N    = 8;
    localparam int NOUT = 4;
    localparam int W    = N * 18;

    logic         clk;
    logic         rst;
    logic [W-1:0] bias;
    logic [W-1:0] sum_in;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready_a,  in_ready_b;
    logic [W-1:0] out_data_a,  out_data_b;
    logic         out_valid_a, out_valid_b;
    logic [1:0]   out_idx_a,   out_idx_b;
    logic         out_last_a,  out_last_b;

    bias_relu_stage #(.N_adder_tree(N), .NUM_OUT(NOUT), .RELU_EN(1)) u_dut_relu (
        .clk(clk), .rst(rst), .bias(bias), .sum_in(sum_in),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_idx(out_idx_a), .out_last(out_last_a)
    );

    bias_relu_stage #(.N_adder_tree(N), .NUM_OUT(NOUT), .RELU_EN(0)) u_dut_pass (
        .clk(clk), .rst(rst), .bias(bias), .sum_in(sum_in),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_idx(out_idx_b), .out_last(out_last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Counters and check helpers
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int n_last   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic int lane(input logic [W-1:0] v, input int i);
        logic signed [17:0] x;
        x = v[18*i +: 18];
        return int'(x);
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] b, input logic [W-1:0] s,
                                           input bit relu);
        logic [W-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < N; i++) begin
            v = lane(b, i) + lane(s, i);
            if (v > 131071)       v = 131071;
            else if (v < -131072) v = -131072;
            if (relu && v < 0)    v = 0;
            r[18*i +: 18] = 18'(v);
        end
        return r;
    endfunction

    function automatic logic [17:0] rand_lane();
        case ($urandom_range(0, 3))
            0:       return 18'($urandom);
            1:       return 18'(131071 - int'($urandom_range(0, 300)));
            2:       return 18'(-131072 + int'($urandom_range(0, 300)));
            default: return 18'(int'($urandom_range(0, 2000)) - 1000);
        endcase
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[18*i +: 18] = rand_lane();
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Compare process: every falling edge, judge what the next rising edge will
    // transfer and check the presented outputs against the model.
    // -------------------------------------------------------------------------
    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];
    int           exp_idx   = 0;
    bit           stall_prev = 1'b0;
    logic [W-1:0] prev_a;
    logic [W-1:0] prev_b;
    logic [1:0]   prev_idx;
    logic [W-1:0] ea, eb;

    always @(negedge clk) begin
        if (rst) begin
            check("in_ready_in_reset", in_ready_a, 1);
            check("in_ready_in_reset_pass", in_ready_b, 1);
            q_a.delete();
            q_b.delete();
            exp_idx    = 0;
            stall_prev = 1'b0;
        end else begin
            check("in_ready", in_ready_a, !out_valid_a || out_ready);
            check("in_ready_pass", in_ready_b, !out_valid_b || out_ready);
            check("spurious_valid", out_valid_a && (q_a.size() == 0), 0);
            check("spurious_valid_pass", out_valid_b && (q_b.size() == 0), 0);
            check("out_last", out_last_a, out_valid_a && (exp_idx == NOUT-1));

            if (stall_prev) begin
                check("stall_valid", out_valid_a, 1);
                check_vec("stall_data", out_data_a, prev_a);
                check_vec("stall_data_pass", out_data_b, prev_b);
                check("stall_idx", out_idx_a, prev_idx);
            end

            if (out_valid_a && out_ready && q_a.size() != 0) begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                check_vec("data_relu", out_data_a, ea);
                check_vec("data_pass", out_data_b, eb);
                check("out_idx", out_idx_a, exp_idx);
                check("out_idx_pass", out_idx_b, exp_idx);
                exp_idx = (exp_idx + 1) % NOUT;
                n_out++;
                if (out_last_a) n_last++;
            end

            if (in_valid && in_ready_a) begin
                q_a.push_back(model(bias, sum_in, 1'b1));
                q_b.push_back(model(bias, sum_in, 1'b0));
            end

            stall_prev = out_valid_a && !out_ready;
            prev_a     = out_data_a;
            prev_b     = out_data_b;
            prev_idx   = out_idx_a;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after the rising edge; the stimulus
    // process only reads DUT outputs at the falling edge.
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    int seq_idx[$];
    int seq_last[$];
    int exp_seq[9]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int exp_lseq[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    int n0, l0, sent;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bias      = '0;
        sum_in    = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state.
        look();
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_idx", out_idx_a, 0);
        check_vec("rst_out_data", out_data_a, '0);
        check_vec("rst_out_data_pass", out_data_b, '0);
        check("rst_in_ready", in_ready_a, 1);

        // Single vector with hand-computed lanes and exact latency.
        step();
        bias   = rand_vec();
        sum_in = rand_vec();
        bias[0*18 +: 18]   = 18'(6484);    sum_in[0*18 +: 18] = 18'(1000);
        bias[1*18 +: 18]   = 18'(131071);  sum_in[1*18 +: 18] = 18'(100);
        bias[2*18 +: 18]   = 18'(-131072); sum_in[2*18 +: 18] = 18'(-100);
        bias[7*18 +: 18]   = 18'(-6404);   sum_in[7*18 +: 18] = 18'(4000);
        in_valid = 1'b1;
        look();
        check("lat_accept", in_ready_a, 1);
        step();
        in_valid = 1'b0;
        look();
        check("lat_cycle1_valid", out_valid_a, 0);
        step();
        look();
        check("lat_cycle2_valid", out_valid_a, 1);
        check("lane0_relu", lane(out_data_a, 0), 7484);
        check("lane7_relu", lane(out_data_a, 7), 0);
        check("lane7_pass", lane(out_data_b, 7), -2404);
        check("lane1_sat_hi", lane(out_data_a, 1), 131071);
        check("lane1_sat_hi_pass", lane(out_data_b, 1), 131071);
        check("lane2_sat_lo_pass", lane(out_data_b, 2), -131072);
        check("lane2_sat_lo_relu", lane(out_data_a, 2), 0);
        step();
        repeat (3) step();

        // Five vectors with a three-cycle output stall in the middle.
        n0   = n_out;
        sent = 0;
        for (int c = 0; c < 15; c++) begin
            in_valid  = (sent < 5);
            sum_in    = rand_vec();
            out_ready = !(c >= 3 && c < 6);
            look();
            if (in_valid && in_ready_a) sent++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        look();
        check("stall_sent", sent, 5);
        check("stall_delivered", n_out - n0, 5);
        check("stall_queue_empty", q_a.size(), 0);
        step();

        // Nine vectors after a fresh reset: index wrap and last flag.
        do_reset(2);
        n0 = n_out;
        l0 = n_last;
        for (int i = 0; i < 13; i++) begin
            in_valid = (i < 9);
            sum_in   = rand_vec();
            look();
            if (out_valid_a && out_ready) begin
                seq_idx.push_back(int'(out_idx_a));
                seq_last.push_back(int'(out_last_a));
            end
            step();
        end
        in_valid = 1'b0;
        check("idx_seq_len", seq_idx.size(), 9);
        for (int i = 0; i < 9 && i < seq_idx.size(); i++) begin
            check("idx_seq", seq_idx[i], exp_seq[i]);
            check("last_seq", seq_last[i], exp_lseq[i]);
        end
        look();
        check("idx_after_nine", out_idx_a, 1);
        check("last_count", n_last - l0, 2);
        step();

        // Reset with two vectors in flight.
        in_valid = 1'b1;
        sum_in   = rand_vec();
        step();
        sum_in   = rand_vec();
        step();
        rst      = 1'b1;
        sum_in   = rand_vec();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        look();
        check("midrst_valid", out_valid_a, 0);
        check("midrst_idx", out_idx_a, 0);
        check("midrst_in_ready", in_ready_a, 1);
        check_vec("midrst_data", out_data_a, '0);
        step();
        repeat (3) step();
        in_valid = 1'b1;
        sum_in   = rand_vec();
        step();
        in_valid = 1'b0;
        look();
        step();
        look();
        check("midrst_next_valid", out_valid_a, 1);
        check("midrst_next_idx", out_idx_a, 0);
        step();

        // Random traffic with random backpressure and one reset.
        bias = rand_vec();
        for (int c = 0; c < 1500; c++) begin
            rst       = (c == 700);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            sum_in    = rand_vec();
            step();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        look();
        check("random_drain_empty", q_a.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded %0d time units", 200000);
        $fatal(1, "timeout");
    end

endmodule
